counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the width of the burst-length inputs; legal values are 2..8.
REQ-002 clock  input  1  SHALL be the sole clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 req  input  2  SHALL carry the requests; bit i is requester i, held high until done[i].
REQ-005 len0  input  LEN_W  SHALL give requester 0's burst length in count ticks (0..2^LEN_W-1).
REQ-006 len1  input  LEN_W  SHALL give requester 1's burst length in count ticks.
REQ-007 gnt  output  2  SHALL be a one-hot grant, or 0 when idle.
REQ-008 done  output  2  SHALL pulse done[i] for one cycle when requester i's burst completes.
REQ-009 result  output  2  SHALL hold the counter value captured at the end of the last burst.
REQ-010 err  output  1  SHALL flag, with done, a captured value not equal to len mod 4.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 cnt_reset  output  1  SHALL drive the shared 2-bit counter's synchronous reset.
REQ-013 cnt_enable  output  1  SHALL drive the shared counter's enable.
REQ-014 cnt_out  input  2  SHALL carry the shared counter's current value.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, RUN, CAPTURE and REPORT; gnt, done, busy, cnt_reset and cnt_enable SHALL decode from registers only, with no combinational input-to-output path.
REQ-016 In IDLE, if any req bit is high, the block SHALL grant the preferred requester if it requests, otherwise the other one, latch that requester's len into a remaining-count register, and go to CLEAR.
REQ-017 The round-robin pointer SHALL prefer requester 0 after reset and SHALL toggle to the other requester on every REPORT.
REQ-018 CLEAR SHALL last exactly 1 cycle with cnt_reset=1; the next state SHALL be CAPTURE if the latched len is 0, otherwise RUN.
REQ-019 RUN SHALL hold cnt_enable=1 for exactly len consecutive cycles, decrementing remaining each cycle and leaving for CAPTURE when remaining reaches 1.
REQ-020 CAPTURE SHALL last 1 cycle, load result<=cnt_out and err<=(cnt_out != len[1:0]), and keep cnt_enable=0 and cnt_reset=0.
REQ-021 REPORT SHALL last 1 cycle with done[g]=1 for the granted requester g, then return to IDLE.
REQ-022 gnt SHALL be held constant from CLEAR through REPORT inclusive and SHALL be 0 in IDLE.
REQ-023 Timing SHALL be: req seen in IDLE cycle T -> CLEAR at T+1, RUN at T+2..T+1+len, CAPTURE at T+2+len, done at T+3+len; with len=0, done is at T+3.
REQ-024 req and len changes after grant SHALL be ignored until the next IDLE, and a dropped req SHALL NOT abort a burst.
REQ-025 result and err SHALL hold their values until the next CAPTURE; err SHALL be meaningful only while done is high.
REQ-026 The IDLE cycle between bursts is mandatory, so back-to-back grants SHALL be separated by at least one idle cycle.

Reset
REQ-027 While reset_n=0: state SHALL be IDLE; gnt, done, busy, cnt_reset, cnt_enable, result and err SHALL be 0; the pointer SHALL prefer requester 0; remaining SHALL be 0.
REQ-028 Assertion of reset_n mid-burst SHALL abort the burst immediately with no done pulse, and the next burst SHALL start with a CLEAR cycle.

Verification
REQ-029 Single request, req=01, len0=5 -> gnt=01 at T+1, one cnt_reset cycle, five cnt_enable cycles, done=01 at T+8, result=1, err=0.
REQ-030 req=11 together, len0=3, len1=6 -> requester 0 served first (result=3), then IDLE, then requester 1 (result=2); both held high -> grants alternate 0,1,0,1.
REQ-031 len1=0 -> no cnt_enable pulse, done=10 at T+3, result=0, err=0.
REQ-032 len0=15 (wrap) -> fifteen enable cycles, result=3, err=0; len0=4 -> result=0.
REQ-033 Counter model stuck at 0 with len0=2 -> done=01 with result=0, err=1.
REQ-034 reset_n pulsed low during RUN -> all outputs 0 at once, no done; a subsequent req=10 is granted to requester 1, with requester 0 preferred only when both request.

Source files
------------

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that runs each granted burst on a shared
// 2-bit external counter and reports the captured count against len mod 4.
module counter_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       result,
  output logic             err,
  output logic             busy,
  output logic             cnt_reset,
  output logic             cnt_enable,
  input  logic [1:0]       cnt_out
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, REPORT} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic [1:0]       gnt_q;
  logic [LEN_W-1:0] remaining, len_q;
  logic             sel;
  logic [LEN_W-1:0] len_sel;

  // ptr names the preferred requester; fall back to the other one
  assign sel     = req[ptr] ? ptr : ~ptr;
  assign len_sel = sel ? len1 : len0;
  assign gnt     = gnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
    done       = 2'b00;
    case (state)
      IDLE:    if (|req) state_nxt = CLEAR;
      CLEAR: begin
        busy      = 1'b1;
        cnt_reset = 1'b1;
        state_nxt = (len_q == '0) ? CAPTURE : RUN;
      end
      RUN: begin
        busy       = 1'b1;
        cnt_enable = 1'b1;
        if (remaining == LEN_W'(1)) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        state_nxt = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        done      = gnt_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= 1'b0;
      gnt_q     <= 2'b00;
      remaining <= '0;
      len_q     <= '0;
      result    <= 2'b00;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gnt_q     <= sel ? 2'b10 : 2'b01;
          len_q     <= len_sel;
          remaining <= len_sel;
        end
        RUN:     remaining <= remaining - LEN_W'(1);
        CAPTURE: begin
          result <= cnt_out;
          err    <= (cnt_out != len_q[1:0]);
        end
        REPORT: begin
          gnt_q <= 2'b00;
          ptr   <= ~ptr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioral 2-bit counter model.
module tb_counter_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0, len1 = 4'd0;
  logic [1:0] gnt, done, result, cnt_out;
  logic       err, busy, cnt_reset, cnt_enable;
  logic [1:0] cnt = 2'b00;
  bit         stuck = 1'b0;
  int         vec = 0, miss = 0;

  counter_arbiter #(.LEN_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .cnt_out(cnt_out)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (cnt_reset)       cnt <= 2'b00;
    else if (cnt_enable) cnt <= cnt + 2'b01;
  end
  assign cnt_out = stuck ? 2'b00 : cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = 2'b00;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Waits for IDLE, applies a request, and records what the burst looked like.
  // k counts cycles after the IDLE cycle in which req was first seen.
  task automatic do_burst(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                          input bit mutate, output int done_at, output logic [1:0] g1,
                          output logic [1:0] done_v, output int n_en, output int n_rst);
    for (int w = 0; w < 5 && busy; w++) tick();
    req = r; len0 = l0; len1 = l1;
    done_at = -1; g1 = 2'b00; done_v = 2'b00; n_en = 0; n_rst = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        g1 = gnt;
        if (mutate) begin req = 2'b00; len0 = 4'd1; len1 = 4'd1; end
      end
      n_en  += int'(cnt_enable);
      n_rst += int'(cnt_reset);
      if (done !== 2'b00) begin
        done_at = k;
        done_v  = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    vec++;
    if ({gnt, done, busy, cnt_reset, cnt_enable} !== 7'd0) begin
      miss++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt, done, busy, cnt_reset, cnt_enable});
    end
    vec++;
    if ({result, err} !== 3'd0) begin
      miss++;
      $display("FAIL reset_result: got %b want 0", {result, err});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int da, ne, nr; logic [1:0] g, dv;
    do_reset();
    do_burst(2'b01, 4'd5, 4'd0, 1'b0, da, g, dv, ne, nr);
    vec++; if (g !== 2'b01) begin miss++; $display("FAIL single_gnt: got %b want 01", g); end
    vec++; if (nr !== 1) begin miss++; $display("FAIL single_nrst: got %0d want 1", nr); end
    vec++; if (ne !== 5) begin miss++; $display("FAIL single_nen: got %0d want 5", ne); end
    vec++; if (da !== 8) begin miss++; $display("FAIL single_done_at: got %0d want 8", da); end
    vec++; if (dv !== 2'b01) begin miss++; $display("FAIL single_done: got %b want 01", dv); end
    vec++; if ({result, err} !== {2'd1, 1'b0}) begin
      miss++; $display("FAIL single_result: got %0d/%b want 1/0", result, err);
    end
  endtask

  task automatic test_both();
    int da, ne, nr; logic [1:0] g, dv;
    do_reset();
    do_burst(2'b11, 4'd3, 4'd6, 1'b0, da, g, dv, ne, nr);
    vec++; if (g !== 2'b01) begin miss++; $display("FAIL both1_gnt: got %b want 01", g); end
    vec++; if (da !== 6) begin miss++; $display("FAIL both1_done_at: got %0d want 6", da); end
    vec++; if (result !== 2'd3) begin miss++; $display("FAIL both1_result: got %0d want 3", result); end
    tick();
    vec++; if ({busy, gnt} !== 3'b000) begin
      miss++; $display("FAIL both_idle_gap: got busy=%b gnt=%b want 0/00", busy, gnt);
    end
    do_burst(2'b11, 4'd3, 4'd6, 1'b0, da, g, dv, ne, nr);
    vec++; if (g !== 2'b10) begin miss++; $display("FAIL both2_gnt: got %b want 10", g); end
    vec++; if (ne !== 6) begin miss++; $display("FAIL both2_nen: got %0d want 6", ne); end
    vec++; if (dv !== 2'b10) begin miss++; $display("FAIL both2_done: got %b want 10", dv); end
    vec++; if (result !== 2'd2) begin miss++; $display("FAIL both2_result: got %0d want 2", result); end
    do_burst(2'b11, 4'd3, 4'd6, 1'b0, da, g, dv, ne, nr);
    vec++; if (g !== 2'b01) begin miss++; $display("FAIL both3_gnt: got %b want 01", g); end
    do_burst(2'b11, 4'd3, 4'd6, 1'b0, da, g, dv, ne, nr);
    vec++; if (g !== 2'b10) begin miss++; $display("FAIL both4_gnt: got %b want 10", g); end
  endtask

  task automatic test_zero_len();
    int da, ne, nr; logic [1:0] g, dv;
    do_reset();
    do_burst(2'b01, 4'd5, 4'd0, 1'b0, da, g, dv, ne, nr);
    do_burst(2'b10, 4'd5, 4'd0, 1'b0, da, g, dv, ne, nr);
    vec++; if (g !== 2'b10) begin miss++; $display("FAIL zero_gnt: got %b want 10", g); end
    vec++; if (ne !== 0) begin miss++; $display("FAIL zero_nen: got %0d want 0", ne); end
    vec++; if (nr !== 1) begin miss++; $display("FAIL zero_nrst: got %0d want 1", nr); end
    vec++; if (da !== 3) begin miss++; $display("FAIL zero_done_at: got %0d want 3", da); end
    vec++; if ({result, err} !== 3'b000) begin
      miss++; $display("FAIL zero_result: got %0d/%b want 0/0", result, err);
    end
  endtask

  task automatic test_wrap();
    int da, ne, nr; logic [1:0] g, dv;
    do_reset();
    do_burst(2'b01, 4'd15, 4'd0, 1'b0, da, g, dv, ne, nr);
    vec++; if (ne !== 15) begin miss++; $display("FAIL wrap15_nen: got %0d want 15", ne); end
    vec++; if (da !== 18) begin miss++; $display("FAIL wrap15_done_at: got %0d want 18", da); end
    vec++; if ({result, err} !== {2'd3, 1'b0}) begin
      miss++; $display("FAIL wrap15_result: got %0d/%b want 3/0", result, err);
    end
    do_burst(2'b01, 4'd4, 4'd0, 1'b0, da, g, dv, ne, nr);
    vec++; if (ne !== 4) begin miss++; $display("FAIL wrap4_nen: got %0d want 4", ne); end
    vec++; if ({result, err} !== {2'd0, 1'b0}) begin
      miss++; $display("FAIL wrap4_result: got %0d/%b want 0/0", result, err);
    end
  endtask

  task automatic test_stuck();
    int da, ne, nr; logic [1:0] g, dv;
    do_reset();
    stuck = 1'b1;
    do_burst(2'b01, 4'd2, 4'd0, 1'b0, da, g, dv, ne, nr);
    stuck = 1'b0;
    vec++; if (dv !== 2'b01) begin miss++; $display("FAIL stuck_done: got %b want 01", dv); end
    vec++; if ({result, err} !== {2'd0, 1'b1}) begin
      miss++; $display("FAIL stuck_result: got %0d/%b want 0/1", result, err);
    end
  endtask

  task automatic test_ignore_changes();
    int da, ne, nr; logic [1:0] g, dv;
    do_reset();
    do_burst(2'b01, 4'd5, 4'd0, 1'b1, da, g, dv, ne, nr);
    vec++; if (ne !== 5) begin miss++; $display("FAIL hold_nen: got %0d want 5", ne); end
    vec++; if (da !== 8) begin miss++; $display("FAIL hold_done_at: got %0d want 8", da); end
    vec++; if (result !== 2'd1) begin miss++; $display("FAIL hold_result: got %0d want 1", result); end
  endtask

  task automatic test_reset_mid();
    int da, ne, nr, nd; logic [1:0] g, dv;
    do_reset();
    stuck = 1'b1;
    do_burst(2'b01, 4'd1, 4'd0, 1'b0, da, g, dv, ne, nr);
    stuck = 1'b0;
    for (int w = 0; w < 5 && busy; w++) tick();
    req = 2'b01; len0 = 4'd7;
    for (int k = 0; k < 4; k++) tick();
    vec++; if (cnt_enable !== 1'b1) begin miss++; $display("FAIL mid_in_run: got %b want 1", cnt_enable); end
    reset_n = 1'b0;
    req = 2'b00;
    #1;
    vec++; if ({gnt, done, busy, cnt_reset, cnt_enable, result, err} !== 10'd0) begin
      miss++; $display("FAIL mid_reset_outs: got %b want 0",
                       {gnt, done, busy, cnt_reset, cnt_enable, result, err});
    end
    tick();
    reset_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nd += int'(done != 2'b00);
    end
    vec++; if (nd !== 0) begin miss++; $display("FAIL mid_no_done: got %0d want 0", nd); end
    do_burst(2'b10, 4'd0, 4'd2, 1'b0, da, g, dv, ne, nr);
    vec++; if (g !== 2'b10) begin miss++; $display("FAIL mid_next_gnt: got %b want 10", g); end
    vec++; if (nr !== 1) begin miss++; $display("FAIL mid_next_nrst: got %0d want 1", nr); end
    vec++; if (da !== 5) begin miss++; $display("FAIL mid_next_done_at: got %0d want 5", da); end
    vec++; if (result !== 2'd2) begin miss++; $display("FAIL mid_next_result: got %0d want 2", result); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_zero_len();
    test_wrap();
    test_stuck();
    test_ignore_changes();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
